// File: rtl/commit_ctrl.sv
// commit_ctrl: commit-side controller behind the reorder buffer.
//   Retires up to two in-order ROB slots per cycle (slot 0 oldest), drives the
//   architectural RAT and free-list release ports, counts retired instructions,
//   and converts retiring events into a one-cycle flush plus front-end redirect.
//   It also owns interrupt injection and the IDLE wait state.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmt_*_i             per-slot retirement info from the ROB (index 0 = oldest)
//   int_pending_i       interrupt pending from CSR
//   eentry_i, era_i     exception entry / exception return address
//   flush_o, redirect_* one-cycle flush and redirect pulse
//   excp_*_o, ertn_o    exception / ERTN report to CSR
//   arat_*_o            architectural RAT write port (2 lanes)
//   fl_rel_*_o          free-list release port (2 lanes)
//   idle_o, instret_o   IDLE level, retired-instruction counter
module commit_ctrl #(
  parameter int PC_W   = 32,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cmt_valid_i,
  input  logic [1:0][PC_W-1:0]   cmt_pc_i,
  input  logic [1:0]             cmt_br_redirect_i,
  input  logic [1:0][PC_W-1:0]   cmt_br_target_i,
  input  logic [1:0]             cmt_excp_valid_i,
  input  logic [1:0][5:0]        cmt_ecode_i,
  input  logic [1:0][PC_W-1:0]   cmt_badv_i,
  input  logic [1:0]             cmt_ertn_i,
  input  logic [1:0]             cmt_idle_i,
  input  logic [1:0]             cmt_serial_i,
  input  logic [1:0]             cmt_we_i,
  input  logic [1:0][AREG_W-1:0] cmt_areg_i,
  input  logic [1:0][PREG_W-1:0] cmt_preg_i,
  input  logic [1:0][PREG_W-1:0] cmt_old_preg_i,
  input  logic [1:0]             cmt_old_valid_i,
  input  logic                   int_pending_i,
  input  logic [PC_W-1:0]        eentry_i,
  input  logic [PC_W-1:0]        era_i,
  output logic                   flush_o,
  output logic                   redirect_valid_o,
  output logic [PC_W-1:0]        redirect_pc_o,
  output logic                   excp_valid_o,
  output logic [5:0]             excp_ecode_o,
  output logic [PC_W-1:0]        excp_epc_o,
  output logic [PC_W-1:0]        excp_badv_o,
  output logic                   ertn_o,
  output logic [1:0]             arat_we_o,
  output logic [1:0][AREG_W-1:0] arat_areg_o,
  output logic [1:0][PREG_W-1:0] arat_preg_o,
  output logic [1:0]             fl_rel_valid_o,
  output logic [1:0][PREG_W-1:0] fl_rel_preg_o,
  output logic                   idle_o,
  output logic [31:0]            instret_o
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_IDLE} state_e;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_e                   state_q, state_d;
  logic [PC_W-1:0]          idle_pc_q, idle_pc_d;
  logic [31:0]              instret_q, instret_d;
  logic                     flush_q, flush_d;
  logic                     redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]          redirect_pc_q, redirect_pc_d;
  logic                     excp_valid_q, excp_valid_d;
  logic [5:0]               excp_ecode_q, excp_ecode_d;
  logic [PC_W-1:0]          excp_epc_q, excp_epc_d;
  logic [PC_W-1:0]          excp_badv_q, excp_badv_d;
  logic                     ertn_q, ertn_d;
  logic [1:0]               arat_we_q, arat_we_d;
  logic [1:0][AREG_W-1:0]   arat_areg_q, arat_areg_d;
  logic [1:0][PREG_W-1:0]   arat_preg_q, arat_preg_d;
  logic [1:0]               fl_rel_valid_q, fl_rel_valid_d;
  logic [1:0][PREG_W-1:0]   fl_rel_preg_q, fl_rel_preg_d;
  logic                     idle_q, idle_d;

  logic [1:0] evt;
  logic [1:0] acc;
  logic       young;

  assign evt = cmt_excp_valid_i | cmt_ertn_i | cmt_br_redirect_i | cmt_idle_i | cmt_serial_i;

  always_comb begin
    state_d          = state_q;
    idle_pc_d        = idle_pc_q;
    instret_d        = instret_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    excp_valid_d     = 1'b0;
    excp_ecode_d     = '0;
    excp_epc_d       = '0;
    excp_badv_d      = '0;
    ertn_d           = 1'b0;
    arat_we_d        = '0;
    arat_areg_d      = '0;
    arat_preg_d      = '0;
    fl_rel_valid_d   = '0;
    fl_rel_preg_d    = '0;
    acc              = '0;
    young            = 1'b0;

    unique case (state_q)
      S_RUN: begin
        // A pending interrupt claims the retire slot before anything commits.
        acc[0] = cmt_valid_i[0] & ~int_pending_i;
        acc[1] = cmt_valid_i[1] & acc[0] & ~evt[0];
        young  = acc[1];

        for (int k = 0; k < 2; k++) begin
          if (acc[k]) begin
            if (cmt_excp_valid_i[k]) begin
              // Faulting slot never becomes architectural: return its new preg.
              fl_rel_valid_d[k] = cmt_we_i[k];
              fl_rel_preg_d[k]  = cmt_we_i[k] ? cmt_preg_i[k] : '0;
            end else begin
              arat_we_d[k]      = cmt_we_i[k];
              arat_areg_d[k]    = cmt_we_i[k] ? cmt_areg_i[k] : '0;
              arat_preg_d[k]    = cmt_we_i[k] ? cmt_preg_i[k] : '0;
              fl_rel_valid_d[k] = cmt_we_i[k] & cmt_old_valid_i[k];
              fl_rel_preg_d[k]  = (cmt_we_i[k] & cmt_old_valid_i[k]) ? cmt_old_preg_i[k] : '0;
              instret_d         = instret_d + 32'd1;
            end
          end
        end

        if (int_pending_i && cmt_valid_i[0]) begin
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = eentry_i;
          excp_valid_d     = 1'b1;
          excp_epc_d       = cmt_pc_i[0];
          state_d          = S_FLUSH;
        end else if (acc[0] && evt[young]) begin
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          state_d          = S_FLUSH;
          if (cmt_excp_valid_i[young]) begin
            redirect_pc_d = eentry_i;
            excp_valid_d  = 1'b1;
            excp_ecode_d  = cmt_ecode_i[young];
            excp_epc_d    = cmt_pc_i[young];
            excp_badv_d   = cmt_badv_i[young];
          end else if (cmt_ertn_i[young]) begin
            redirect_pc_d = era_i;
            ertn_d        = 1'b1;
          end else if (cmt_br_redirect_i[young]) begin
            redirect_pc_d = cmt_br_target_i[young];
          end else if (cmt_idle_i[young]) begin
            redirect_pc_d = cmt_pc_i[young] + PC_STEP;
            idle_pc_d     = cmt_pc_i[young] + PC_STEP;
            state_d       = S_IDLE;
          end else begin
            redirect_pc_d = cmt_pc_i[young] + PC_STEP;
          end
        end
      end

      // Everything presented during the flush cycle is wrong-path.
      S_FLUSH: state_d = S_RUN;

      S_IDLE: begin
        if (int_pending_i) begin
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = eentry_i;
          excp_valid_d     = 1'b1;
          excp_epc_d       = idle_pc_q;
          state_d          = S_FLUSH;
        end
      end

      default: state_d = S_RUN;
    endcase

    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_RUN;
      idle_pc_q        <= '0;
      instret_q        <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      excp_valid_q     <= 1'b0;
      excp_ecode_q     <= '0;
      excp_epc_q       <= '0;
      excp_badv_q      <= '0;
      ertn_q           <= 1'b0;
      arat_we_q        <= '0;
      arat_areg_q      <= '0;
      arat_preg_q      <= '0;
      fl_rel_valid_q   <= '0;
      fl_rel_preg_q    <= '0;
      idle_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idle_pc_q        <= idle_pc_d;
      instret_q        <= instret_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      excp_valid_q     <= excp_valid_d;
      excp_ecode_q     <= excp_ecode_d;
      excp_epc_q       <= excp_epc_d;
      excp_badv_q      <= excp_badv_d;
      ertn_q           <= ertn_d;
      arat_we_q        <= arat_we_d;
      arat_areg_q      <= arat_areg_d;
      arat_preg_q      <= arat_preg_d;
      fl_rel_valid_q   <= fl_rel_valid_d;
      fl_rel_preg_q    <= fl_rel_preg_d;
      idle_q           <= idle_d;
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign excp_valid_o     = excp_valid_q;
  assign excp_ecode_o     = excp_ecode_q;
  assign excp_epc_o       = excp_epc_q;
  assign excp_badv_o      = excp_badv_q;
  assign ertn_o           = ertn_q;
  assign arat_we_o        = arat_we_q;
  assign arat_areg_o      = arat_areg_q;
  assign arat_preg_o      = arat_preg_q;
  assign fl_rel_valid_o   = fl_rel_valid_q;
  assign fl_rel_preg_o    = fl_rel_preg_q;
  assign idle_o           = idle_q;
  assign instret_o        = instret_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Testbench for commit_ctrl: directed commit groups, a cycle-level reference
// model of the retirement rules, and literal spot checks of key results.
module tb_commit_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        cmt_valid, cmt_br, cmt_excp, cmt_ertn, cmt_idle, cmt_serial, cmt_we, cmt_ov;
  logic [1:0][31:0]  cmt_pc, cmt_tgt, cmt_badv;
  logic [1:0][5:0]   cmt_ecode, cmt_preg, cmt_opreg;
  logic [1:0][4:0]   cmt_areg;
  logic              int_pending;
  logic [31:0]       eentry, era;
  logic              preset_ir = 1'b0;

  logic              flush_o, redirect_valid_o, excp_valid_o, ertn_o, idle_o;
  logic [31:0]       redirect_pc_o, excp_epc_o, excp_badv_o, instret_o;
  logic [5:0]        excp_ecode_o;
  logic [1:0]        arat_we_o, fl_rel_valid_o;
  logic [1:0][4:0]   arat_areg_o;
  logic [1:0][5:0]   arat_preg_o, fl_rel_preg_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  commit_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_valid_i(cmt_valid), .cmt_pc_i(cmt_pc),
    .cmt_br_redirect_i(cmt_br), .cmt_br_target_i(cmt_tgt),
    .cmt_excp_valid_i(cmt_excp), .cmt_ecode_i(cmt_ecode), .cmt_badv_i(cmt_badv),
    .cmt_ertn_i(cmt_ertn), .cmt_idle_i(cmt_idle), .cmt_serial_i(cmt_serial),
    .cmt_we_i(cmt_we), .cmt_areg_i(cmt_areg), .cmt_preg_i(cmt_preg),
    .cmt_old_preg_i(cmt_opreg), .cmt_old_valid_i(cmt_ov),
    .int_pending_i(int_pending), .eentry_i(eentry), .era_i(era),
    .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .excp_valid_o(excp_valid_o), .excp_ecode_o(excp_ecode_o), .excp_epc_o(excp_epc_o),
    .excp_badv_o(excp_badv_o), .ertn_o(ertn_o),
    .arat_we_o(arat_we_o), .arat_areg_o(arat_areg_o), .arat_preg_o(arat_preg_o),
    .fl_rel_valid_o(fl_rel_valid_o), .fl_rel_preg_o(fl_rel_preg_o),
    .idle_o(idle_o), .instret_o(instret_o)
  );

  // ---------------- reference model ----------------
  localparam logic [1:0] M_RUN = 2'd0, M_FLUSH = 2'd1, M_IDLE = 2'd2;

  typedef struct packed {
    logic [1:0]      mode;
    logic [31:0]     spc;
    logic [31:0]     ir;
    logic            flush;
    logic            rv;
    logic [31:0]     rpc;
    logic            ev;
    logic [5:0]      ec;
    logic [31:0]     epc;
    logic [31:0]     badv;
    logic            ertn;
    logic [1:0]      awe;
    logic [1:0][4:0] aar;
    logic [1:0][5:0] apr;
    logic [1:0]      frv;
    logic [1:0][5:0] frp;
    logic            idle;
  } mdl_t;

  mdl_t exp_q;

  function automatic logic has_evt(input int k);
    return cmt_excp[k] | cmt_ertn[k] | cmt_br[k] | cmt_idle[k] | cmt_serial[k];
  endfunction

  function automatic mdl_t model_step(input mdl_t cur, input logic preset);
    mdl_t n;
    int   cnt;
    int   last;
    n      = '0;
    n.mode = cur.mode;
    n.spc  = cur.spc;
    n.ir   = preset ? 32'hFFFF_FFFF : cur.ir;
    case (cur.mode)
      M_RUN: begin
        if (cmt_valid[0] && int_pending) begin
          n.ev = 1'b1; n.ec = 6'd0; n.epc = cmt_pc[0]; n.badv = 32'd0;
          n.flush = 1'b1; n.rv = 1'b1; n.rpc = eentry; n.mode = M_FLUSH;
        end else begin
          cnt = 0;
          if (cmt_valid[0]) cnt = (cmt_valid[1] && !has_evt(0)) ? 2 : 1;
          for (int i = 0; i < cnt; i++) begin
            if (cmt_excp[i]) begin
              if (cmt_we[i]) begin n.frv[i] = 1'b1; n.frp[i] = cmt_preg[i]; end
            end else begin
              n.ir = n.ir + 32'd1;
              if (cmt_we[i]) begin
                n.awe[i] = 1'b1; n.aar[i] = cmt_areg[i]; n.apr[i] = cmt_preg[i];
                if (cmt_ov[i]) begin n.frv[i] = 1'b1; n.frp[i] = cmt_opreg[i]; end
              end
            end
          end
          if (cnt > 0 && has_evt(cnt - 1)) begin
            last = cnt - 1;
            n.flush = 1'b1; n.rv = 1'b1; n.mode = M_FLUSH;
            if (cmt_excp[last]) begin
              n.rpc = eentry; n.ev = 1'b1; n.ec = cmt_ecode[last];
              n.epc = cmt_pc[last]; n.badv = cmt_badv[last];
            end else if (cmt_ertn[last]) begin
              n.rpc = era; n.ertn = 1'b1;
            end else if (cmt_br[last]) begin
              n.rpc = cmt_tgt[last];
            end else if (cmt_idle[last]) begin
              n.rpc = cmt_pc[last] + 32'd4; n.spc = cmt_pc[last] + 32'd4;
              n.mode = M_IDLE; n.idle = 1'b1;
            end else begin
              n.rpc = cmt_pc[last] + 32'd4;
            end
          end
        end
      end
      M_FLUSH: n.mode = M_RUN;
      default: begin
        n.idle = 1'b1;
        if (int_pending) begin
          n.ev = 1'b1; n.ec = 6'd0; n.epc = cur.spc; n.badv = 32'd0;
          n.flush = 1'b1; n.rv = 1'b1; n.rpc = eentry; n.mode = M_FLUSH; n.idle = 1'b0;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else        exp_q <= model_step(exp_q, preset_ir);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model; data fields only where qualified.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_flush", 64'(flush_o), 64'(exp_q.flush));
      chk("m_rv", 64'(redirect_valid_o), 64'(exp_q.rv));
      if (exp_q.rv) chk("m_rpc", 64'(redirect_pc_o), 64'(exp_q.rpc));
      chk("m_ev", 64'(excp_valid_o), 64'(exp_q.ev));
      if (exp_q.ev) begin
        chk("m_ecode", 64'(excp_ecode_o), 64'(exp_q.ec));
        chk("m_epc", 64'(excp_epc_o), 64'(exp_q.epc));
        chk("m_badv", 64'(excp_badv_o), 64'(exp_q.badv));
      end
      chk("m_ertn", 64'(ertn_o), 64'(exp_q.ertn));
      chk("m_awe", 64'(arat_we_o), 64'(exp_q.awe));
      chk("m_frv", 64'(fl_rel_valid_o), 64'(exp_q.frv));
      for (int k = 0; k < 2; k++) begin
        if (exp_q.awe[k]) begin
          chk("m_areg", 64'(arat_areg_o[k]), 64'(exp_q.aar[k]));
          chk("m_apreg", 64'(arat_preg_o[k]), 64'(exp_q.apr[k]));
        end
        if (exp_q.frv[k]) chk("m_frpreg", 64'(fl_rel_preg_o[k]), 64'(exp_q.frp[k]));
      end
      chk("m_idle", 64'(idle_o), 64'(exp_q.idle));
      chk("m_instret", 64'(instret_o), 64'(exp_q.ir));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    cmt_valid = '0; cmt_br = '0; cmt_excp = '0; cmt_ertn = '0; cmt_idle = '0;
    cmt_serial = '0; cmt_we = '0; cmt_ov = '0; cmt_pc = '0; cmt_tgt = '0;
    cmt_badv = '0; cmt_ecode = '0; cmt_preg = '0; cmt_opreg = '0; cmt_areg = '0;
    int_pending = 1'b0;
  endtask

  task automatic alu(input int k, input logic [31:0] pc, input logic [4:0] ar,
                     input logic [5:0] pr, input logic [5:0] op);
    cmt_valid[k] = 1'b1; cmt_pc[k] = pc; cmt_we[k] = 1'b1;
    cmt_areg[k] = ar; cmt_preg[k] = pr; cmt_opreg[k] = op; cmt_ov[k] = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    clr();
    eentry = 32'h1c00_8000;
    era    = 32'h1c00_0500;
    repeat (3) cyc();
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_rpc", 64'(redirect_pc_o), 64'd0);
    chk("rst_instret", 64'(instret_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd0);
    chk("rst_awe", 64'(arat_we_o), 64'd0);
    rst_n = 1'b1;

    // two plain ALU slots
    alu(0, 32'h1c00_0000, 5'd3, 6'd10, 6'd5);
    alu(1, 32'h1c00_0004, 5'd4, 6'd11, 6'd6);
    cyc(); clr();
    chk("alu_awe", 64'(arat_we_o), 64'h3);
    chk("alu_areg1", 64'(arat_areg_o[1]), 64'd4);
    chk("alu_preg0", 64'(arat_preg_o[0]), 64'd10);
    chk("alu_rel", 64'({fl_rel_preg_o[1], fl_rel_preg_o[0]}), 64'({6'd6, 6'd5}));
    chk("alu_instret", 64'(instret_o), 64'd2);
    chk("alu_flush", 64'(flush_o), 64'd0);

    // branch mispredict in slot 0, slot 1 must not commit
    alu(0, 32'h1c00_00f0, 5'd1, 6'd20, 6'd2);
    cmt_br[0] = 1'b1; cmt_tgt[0] = 32'h1c00_0100;
    alu(1, 32'h1c00_00f4, 5'd7, 6'd21, 6'd8);
    cyc(); clr();
    chk("br_flush", 64'(flush_o), 64'd1);
    chk("br_rpc", 64'(redirect_pc_o), 64'h1c00_0100);
    chk("br_awe", 64'(arat_we_o), 64'h1);
    chk("br_instret", 64'(instret_o), 64'd3);
    alu(0, 32'h1c00_0100, 5'd9, 6'd22, 6'd9);   // arrives during the flush cycle
    cyc(); clr();
    chk("flush_ign_awe", 64'(arat_we_o), 64'd0);
    chk("flush_ign_instret", 64'(instret_o), 64'd3);

    // slot 1 exception
    alu(0, 32'h1c00_003c, 5'd2, 6'd13, 6'd3);
    alu(1, 32'h1c00_0040, 5'd8, 6'd12, 6'd4);
    cmt_excp[1] = 1'b1; cmt_ecode[1] = 6'h8; cmt_badv[1] = 32'h7;
    cyc(); clr();
    chk("ex_awe", 64'(arat_we_o), 64'h1);
    chk("ex_rel", 64'(fl_rel_valid_o), 64'h3);
    chk("ex_relpreg1", 64'(fl_rel_preg_o[1]), 64'd12);
    chk("ex_valid", 64'(excp_valid_o), 64'd1);
    chk("ex_ecode", 64'(excp_ecode_o), 64'h8);
    chk("ex_epc", 64'(excp_epc_o), 64'h1c00_0040);
    chk("ex_badv", 64'(excp_badv_o), 64'h7);
    chk("ex_rpc", 64'(redirect_pc_o), 64'h1c00_8000);
    chk("ex_instret", 64'(instret_o), 64'd4);
    cyc();

    // interrupt injection
    alu(0, 32'h200, 5'd5, 6'd30, 6'd31);
    int_pending = 1'b1;
    cyc(); clr();
    chk("int_ev", 64'(excp_valid_o), 64'd1);
    chk("int_epc", 64'(excp_epc_o), 64'h200);
    chk("int_ecode", 64'(excp_ecode_o), 64'd0);
    chk("int_flush", 64'(flush_o), 64'd1);
    chk("int_awe", 64'(arat_we_o), 64'd0);
    cyc();

    // IDLE, then wake by interrupt
    cmt_valid[0] = 1'b1; cmt_pc[0] = 32'h300; cmt_idle[0] = 1'b1;
    cyc(); clr();
    chk("idle_rpc", 64'(redirect_pc_o), 64'h304);
    chk("idle_lvl", 64'(idle_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      alu(0, 32'h304, 5'd6, 6'd40, 6'd41);
      cyc();
      chk("idle_hold", 64'(idle_o), 64'd1);
      chk("idle_ign", 64'(arat_we_o), 64'd0);
    end
    clr(); int_pending = 1'b1;
    cyc(); clr();
    chk("wake_ev", 64'(excp_valid_o), 64'd1);
    chk("wake_epc", 64'(excp_epc_o), 64'h304);
    chk("wake_idle", 64'(idle_o), 64'd0);
    chk("wake_instret", 64'(instret_o), 64'd5);
    cyc();

    // ERTN
    cmt_valid[0] = 1'b1; cmt_pc[0] = 32'h1c00_0600; cmt_ertn[0] = 1'b1;
    cyc(); clr();
    chk("ertn_o", 64'(ertn_o), 64'd1);
    chk("ertn_rpc", 64'(redirect_pc_o), 64'h1c00_0500);
    cyc();

    // serialising flush on slot 1, and pc+4 wrap
    alu(0, 32'h400, 5'd10, 6'd14, 6'd15);
    cmt_valid[1] = 1'b1; cmt_pc[1] = 32'h404; cmt_serial[1] = 1'b1;
    cyc(); clr();
    chk("ser_rpc", 64'(redirect_pc_o), 64'h408);
    chk("ser_instret", 64'(instret_o), 64'd8);
    cyc();
    cmt_valid[0] = 1'b1; cmt_pc[0] = 32'hFFFF_FFFC; cmt_serial[0] = 1'b1;
    cyc(); clr();
    chk("wrap_rpc", 64'(redirect_pc_o), 64'd0);
    chk("wrap_rv", 64'(redirect_valid_o), 64'd1);
    cyc();

    // reset while in IDLE
    cmt_valid[0] = 1'b1; cmt_pc[0] = 32'h600; cmt_idle[0] = 1'b1;
    cyc(); clr();
    chk("idle2_lvl", 64'(idle_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsti_idle", 64'(idle_o), 64'd0);
    chk("rsti_flush", 64'(flush_o), 64'd0);
    chk("rsti_instret", 64'(instret_o), 64'd0);
    cyc(); rst_n = 1'b1;
    alu(0, 32'h700, 5'd1, 6'd1, 6'd2);
    alu(1, 32'h704, 5'd2, 6'd3, 6'd4);
    cyc(); clr();
    chk("post_rst_awe", 64'(arat_we_o), 64'h3);
    chk("post_rst_instret", 64'(instret_o), 64'd2);

    // reset during the flush cycle
    cmt_valid[0] = 1'b1; cmt_pc[0] = 32'h800; cmt_br[0] = 1'b1; cmt_tgt[0] = 32'h900;
    cyc(); clr();
    chk("rstf_pre", 64'(flush_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_flush", 64'(flush_o), 64'd0);
    chk("rstf_rv", 64'(redirect_valid_o), 64'd0);
    cyc(); rst_n = 1'b1;
    alu(0, 32'h900, 5'd3, 6'd5, 6'd6);
    cyc(); clr();
    chk("rstf_resume", 64'(arat_we_o), 64'h1);

    // instret wrap: preset to all-ones, then two more commits
    #2 force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    preset_ir = 1'b1;
    alu(0, 32'hA00, 5'd1, 6'd7, 6'd8);
    alu(1, 32'hA04, 5'd2, 6'd9, 6'd10);
    cyc(); clr(); preset_ir = 1'b0;
    chk("instret_wrap", 64'(instret_o), 64'd1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

Commit-side controller directly downstream of the reorder buffer. Each cycle it consumes up to two in-order retiring ROB entries and performs architectural updates: register-map update, physical-register release and an instruction-retired counter. It turns retiring branch mispredicts, exceptions, ERTN, IDLE and serialising flushes into a one-cycle pipeline flush plus a front-end redirect. It also owns interrupt injection and the IDLE wait state.

## Interface

- `PC_W`, 32: PC / address width.
- `AREG_W`, 5: architectural register index width.
- `PREG_W`, 6: physical register index width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmt_valid_i` in 2: ROB retiring slot valid; slot 0 is the oldest. `cmt_valid_i[1]` implies `cmt_valid_i[0]`.
- `cmt_pc_i` in 2×PC_W: PC of each slot.
- `cmt_br_redirect_i` in 2: slot was a mispredicted branch.
- `cmt_br_target_i` in 2×PC_W: correct target of the branch.
- `cmt_excp_valid_i` in 2: slot raised an exception.
- `cmt_ecode_i` in 2×6: exception code.
- `cmt_badv_i` in 2×PC_W: faulting address.
- `cmt_ertn_i`, `cmt_idle_i`, `cmt_serial_i` in 2 each: ERTN / IDLE / serialising flush (priv, ibar, icacop).
- `cmt_we_i` in 2: slot writes a destination register.
- `cmt_areg_i` in 2×AREG_W: architectural destination register.
- `cmt_preg_i` in 2×PREG_W: new physical register.
- `cmt_old_preg_i` in 2×PREG_W: previous physical register.
- `cmt_old_valid_i` in 2: previous physical register is valid.
- `int_pending_i` in 1: interrupt pending from CSR.
- `eentry_i` in PC_W: exception entry address.
- `era_i` in PC_W: exception return address.
- `flush_o` out 1: pipeline/ROB flush pulse.
- `redirect_valid_o` out 1: front-end redirect request.
- `redirect_pc_o` out PC_W: redirect target.
- `excp_valid_o` out 1: exception/interrupt taken.
- `excp_ecode_o` out 6: code of the taken exception.
- `excp_epc_o` out PC_W: exception return PC.
- `excp_badv_o` out PC_W: faulting address.
- `ertn_o` out 1: ERTN retired (CSR restores PRMD).
- `arat_we_o` out 2: architectural RAT write enable.
- `arat_areg_o` out 2×AREG_W: architectural RAT index.
- `arat_preg_o` out 2×PREG_W: architectural RAT data.
- `fl_rel_valid_o` out 2: free-list release valid.
- `fl_rel_preg_o` out 2×PREG_W: physical register returned to the free list.
- `idle_o` out 1: core is in IDLE.
- `instret_o` out 32: count of retired instructions.

## Operation

FSM states: RUN, FLUSH, IDLE. Reset enters RUN.

Accepted slots in RUN:
- Slot 0 is accepted when it is valid and no interrupt is being injected.
- Slot 1 is accepted when it is valid, slot 0 is accepted, and slot 0 carries no event.
- An event is any of excp, ertn, br_redirect, idle, serial.

Per accepted slot k:
- `arat_we[k] = we`.
- `fl_rel_valid[k] = we & old_valid`, with `fl_rel_preg[k] = old_preg`.
- Exception: if the slot has an exception, suppress both `arat_we` and the release for that slot, and release `preg` instead if `we`.

Event of the youngest accepted slot, by priority:
1. excp: redirect to `eentry_i`; `excp_ecode = ecode`, `epc = pc`, `badv = badv`.
2. ertn: redirect to `era_i`; `ertn_o = 1`.
3. br_redirect: redirect to `br_target`.
4. idle: redirect to `pc+4`; next state IDLE instead of FLUSH.
5. serial: redirect to `pc+4`.

Any event moves the FSM to FLUSH (or IDLE for idle).

Interrupt injection:
- In RUN, `int_pending_i` with `cmt_valid_i[0]` suppresses both slots.
- It takes an exception with ecode 0, `epc = slot0 pc`, `badv = 0`, redirect to `eentry_i`, and moves to FLUSH.
- With no valid slot, the interrupt waits.

FLUSH lasts one cycle. All `cmt_*` inputs are ignored (wrong-path/flushed), then the FSM returns to RUN.

IDLE:
- Ignores commits, holds `idle_o = 1`.
- On `int_pending_i` it takes the interrupt with `epc = saved idle pc+4`, redirect to `eentry_i`, and moves to FLUSH.

`instret` adds the number of accepted slots whose exception is clear, wrapping mod 2^32. An interrupt adds 0.

## Timing

- Acceptance is combinational on cycle T inputs. All outputs are registered and appear in T+1 as one-cycle pulses. `idle_o` and `instret_o` are levels.
- `flush_o`, `redirect_valid_o` and `excp_valid_o` (when applicable) assert together in the same cycle, exactly one cycle.
- Reset values: every output is 0, `redirect_pc_o = 0`, `instret_o = 0`, state RUN, saved idle PC 0.
- Reset mid-FLUSH or mid-IDLE returns to RUN with all pulses dropped.
- Back-to-back: an event in T gives FLUSH in T+1. Inputs in T+1 are discarded. Inputs in T+2 are processed normally.
- `instret` wraps from 0xFFFFFFFF to 0 or 1 with no saturation.
- `pc+4` is computed mod 2^PC_W.

## Test plan

- Two plain ALU slots with `we`, areg 3/4, preg 10/11, old 5/6 valid -> next cycle `arat_we = 2'b11` with those values, `fl_rel` of 5 and 6, `instret` +2, no flush.
- Slot 0 `br_redirect`, target 0x1c000100, slot 1 valid -> only slot 0 committed; next cycle flush and redirect to 0x1c000100. A valid input in the FLUSH cycle is ignored.
- Slot 1 exception ecode 0x8, pc 0x1c000040, badv 0x7, `eentry` 0x1c008000 -> slot 0 committed; slot 1 releases its preg with no RAT write; `excp_valid = 1` with ecode 8, epc 0x1c000040, badv 0x7; redirect 0x1c008000; `instret` +1.
- `int_pending` with slot 0 valid at pc 0x200 -> no commit; exception ecode 0, epc 0x200; flush pulse.
- IDLE at pc 0x300 -> redirect 0x304 and `idle_o = 1` held for 10 cycles while inputs are ignored. An interrupt then produces an exception with epc 0x304 and `idle_o` falls.
- `rst_n` low during IDLE or FLUSH -> all outputs 0 immediately; normal commits resume after release. `instret` preset by 0xFFFFFFFF commits plus two more -> wraps to 1.
